// File: rtl/mm_pkg.sv
// Shared definitions for the systolic-array result drain: default sizes,
// FSM state encoding and the PE-index width helper.
// No ports; imported by mm_result_drain.
package mm_pkg;

  localparam int DEF_ACC_WIDTH = 32;
  localparam int DEF_EXP_WIDTH = 5;
  localparam int DEF_N         = 2;

  // Drain FSM encoding: IDLE waits for a job, STREAM presents beats.
  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_STREAM = 1'b1;

  // Width of a PE index for an n x n array, never narrower than one bit.
  function automatic int idx_width(input int n);
    int w;
    w = $clog2(n * n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector: registers the previous input level and pulses for
// one cycle when the input is high and the registered copy is low.
// Latency: combinational pulse, valid in the cycle the level first reads 1.
// Ports: clk, rst (sync active-low), d_i level in, pulse_o rise pulse out.
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic pulse_o
);

  logic d_q;

  // Clearing d_q on reset makes a level already high at release count as a rise.
  always_ff @(posedge clk) begin
    if (!rst) begin
      d_q <= 1'b0;
    end else begin
      d_q <= d_i;
    end
  end

  assign pulse_o = d_i & ~d_q;

endmodule

// File: rtl/mm_result_drain.sv
// Drains the N*N accumulator/exponent results of a finished systolic job as a
// valid/ready stream, one PE per beat, index 0 first.
// Latency: first beat one cycle after the capture edge. Backpressure: beat
// holds while out_ready=0; a job arriving mid-stream is dropped and flagged.
// Ports: clk, rst (sync active-low), done, acc_in/exp_in (flattened PE
// results), out_valid/out_ready handshake, out_acc/out_exp/out_idx/out_last
// beat payload, busy (job in flight), overrun (sticky dropped-job flag).
module mm_result_drain
  import mm_pkg::*;
#(
  parameter int ACC_WIDTH = DEF_ACC_WIDTH,
  parameter int EXP_WIDTH = DEF_EXP_WIDTH,
  parameter int N         = DEF_N
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          done,
  input  logic [N*N*ACC_WIDTH-1:0]      acc_in,
  input  logic [N*N*EXP_WIDTH-1:0]      exp_in,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [ACC_WIDTH-1:0]          out_acc,
  output logic [EXP_WIDTH-1:0]          out_exp,
  output logic [idx_width(N)-1:0]       out_idx,
  output logic                          out_last,
  output logic                          busy,
  output logic                          overrun
);

  localparam int NN = N * N;
  localparam int IW = idx_width(N);
  localparam logic [IW-1:0] LAST_IDX = IW'(NN - 1);

  logic [0:0]           state_q, state_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic                 overrun_q, overrun_d;
  logic [ACC_WIDTH-1:0] acc_sh_q [NN];
  logic [EXP_WIDTH-1:0] exp_sh_q [NN];

  logic done_rise;
  logic streaming;
  logic at_last;
  logic xfer;
  logic last_xfer;
  logic capture;

  rise_detect u_done_rise (
    .clk     (clk),
    .rst     (rst),
    .d_i     (done),
    .pulse_o (done_rise)
  );

  assign streaming = (state_q == ST_STREAM);
  assign at_last   = (idx_q == LAST_IDX);
  assign xfer      = streaming & out_ready;
  assign last_xfer = xfer & at_last;
  // The shadow copy is free either when idle or on the edge its last beat leaves,
  // so a job landing exactly then chains on without a bubble.
  assign capture   = done_rise & (~streaming | last_xfer);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    overrun_d = overrun_q | (done_rise & streaming & ~last_xfer);
    if (capture) begin
      state_d = ST_STREAM;
      idx_d   = '0;
    end else if (last_xfer) begin
      state_d = ST_IDLE;
      idx_d   = '0;
    end else if (xfer) begin
      idx_d = idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      overrun_q <= 1'b0;
      for (int i = 0; i < NN; i++) begin
        acc_sh_q[i] <= '0;
        exp_sh_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      overrun_q <= overrun_d;
      if (capture) begin
        for (int i = 0; i < NN; i++) begin
          acc_sh_q[i] <= acc_in[i*ACC_WIDTH +: ACC_WIDTH];
          exp_sh_q[i] <= exp_in[i*EXP_WIDTH +: EXP_WIDTH];
        end
      end
    end
  end

  // Payload is a straight mux off the shadow copy, so it is stable whenever
  // idx_q is, i.e. throughout any stall.
  assign out_valid = streaming;
  assign busy      = streaming;
  assign out_idx   = idx_q;
  assign out_last  = streaming & at_last;
  assign out_acc   = acc_sh_q[idx_q];
  assign out_exp   = exp_sh_q[idx_q];
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_mm_result_drain.sv
module tb_mm_result_drain;

  logic         clk;
  logic         rst;
  logic         done;
  logic [127:0] acc_in;
  logic [19:0]  exp_in;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_acc;
  logic [4:0]   out_exp;
  logic [1:0]   out_idx;
  logic         out_last;
  logic         busy;
  logic         overrun;

  int total;
  int bad;

  localparam logic [127:0] JOB_A = {32'hFFFFAC00, 32'hFFFFAC00, 32'hFFFF9000, 32'hFFFFBC00};
  localparam logic [19:0]  EXP_A = {5'd15, 5'd15, 5'd15, 5'd15};

  logic [31:0] acc_tbl [4];
  logic        rdy_tbl [7];

  mm_result_drain dut (
    .clk       (clk),
    .rst       (rst),
    .done      (done),
    .acc_in    (acc_in),
    .exp_in    (exp_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_acc   (out_acc),
    .out_exp   (out_exp),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .busy      (busy),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // One beat of job A at PE index k.
  task automatic beat_a(input string tag, input int k);
    chk({tag, "_vld"},  {63'd0, out_valid}, 64'd1);
    chk({tag, "_idx"},  {62'd0, out_idx},   64'(k));
    chk({tag, "_acc"},  {32'd0, out_acc},   {32'd0, acc_tbl[k]});
    chk({tag, "_exp"},  {59'd0, out_exp},   64'd15);
    chk({tag, "_last"}, {63'd0, out_last},  (k == 3) ? 64'd1 : 64'd0);
    chk({tag, "_busy"}, {63'd0, busy},      64'd1);
  endtask

  task automatic idle_chk(input string tag);
    chk({tag, "_vld"},  {63'd0, out_valid}, 64'd0);
    chk({tag, "_busy"}, {63'd0, busy},      64'd0);
    chk({tag, "_idx"},  {62'd0, out_idx},   64'd0);
    chk({tag, "_last"}, {63'd0, out_last},  64'd0);
  endtask

  initial begin
    int exp_idx;
    int beats;
    total = 0;
    bad   = 0;
    acc_tbl = '{32'hFFFFBC00, 32'hFFFF9000, 32'hFFFFAC00, 32'hFFFFAC00};
    rdy_tbl = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

    rst = 1'b0; done = 1'b0; out_ready = 1'b0;
    acc_in = JOB_A; exp_in = EXP_A;
    repeat (2) @(negedge clk);
    idle_chk("rst");
    chk("rst_ovr", {63'd0, overrun}, 64'd0);
    chk("rst_acc", {32'd0, out_acc}, 64'd0);
    chk("rst_exp", {59'd0, out_exp}, 64'd0);
    rst = 1'b1;

    // Capture and drain at full rate.
    out_ready = 1'b1; done = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      beat_a("drain", k);
      done = 1'b0;
    end
    @(negedge clk);
    idle_chk("drain_end");

    // Back-to-back: new job lands on the last-beat transfer edge.
    done = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      beat_a("b2b_a", k);
      done = 1'b0;
      if (k == 3) begin
        done   = 1'b1;
        acc_in = {4{32'h00000001}};
        exp_in = {4{5'd7}};
      end
    end
    @(negedge clk);
    chk("b2b_vld", {63'd0, out_valid}, 64'd1);
    chk("b2b_idx", {62'd0, out_idx},   64'd0);
    chk("b2b_acc", {32'd0, out_acc},   64'd1);
    chk("b2b_exp", {59'd0, out_exp},   64'd7);
    chk("b2b_ovr", {63'd0, overrun},   64'd0);
    done = 1'b0;
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      chk("b2b_b_idx",  {62'd0, out_idx},  64'(k));
      chk("b2b_b_acc",  {32'd0, out_acc},  64'd1);
      chk("b2b_b_last", {63'd0, out_last}, (k == 3) ? 64'd1 : 64'd0);
    end
    @(negedge clk);
    idle_chk("b2b_end");
    acc_in = JOB_A; exp_in = EXP_A;

    // Backpressure: ready pattern 0,0,1,0,1,1,1.
    out_ready = 1'b0; done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    exp_idx = 0;
    for (int k = 0; k < 7; k++) begin
      beat_a("bp", exp_idx);
      out_ready = rdy_tbl[k];
      @(negedge clk);
      if (rdy_tbl[k]) exp_idx++;
    end
    idle_chk("bp_end");

    // Overrun: second rise at idx1, with inputs changed after capture.
    out_ready = 1'b1; done = 1'b1;
    @(negedge clk);
    beat_a("ovr", 0);
    done = 1'b0;
    @(negedge clk);
    beat_a("ovr", 1);
    chk("ovr_pre", {63'd0, overrun}, 64'd0);
    done = 1'b1;
    acc_in = {4{32'h12345678}};
    exp_in = {4{5'd3}};
    @(negedge clk);
    chk("ovr_set", {63'd0, overrun}, 64'd1);
    beat_a("ovr", 2);
    done = 1'b0;
    @(negedge clk);
    beat_a("ovr", 3);
    @(negedge clk);
    idle_chk("ovr_end");
    chk("ovr_sticky", {63'd0, overrun}, 64'd1);
    acc_in = JOB_A; exp_in = EXP_A;

    // Reset mid-stream, then done already high at reset release.
    done = 1'b1;
    @(negedge clk);
    beat_a("mrst", 0);
    done = 1'b0;
    @(negedge clk);
    beat_a("mrst", 1);
    @(negedge clk);
    beat_a("mrst", 2);
    rst = 1'b0;
    @(negedge clk);
    idle_chk("mrst_in");
    chk("mrst_ovr", {63'd0, overrun}, 64'd0);
    chk("mrst_acc", {32'd0, out_acc}, 64'd0);
    done = 1'b1;
    @(negedge clk);
    chk("mrst_hold_vld", {63'd0, out_valid}, 64'd0);
    rst = 1'b1;
    @(negedge clk);
    beat_a("mrst_re", 0);
    done = 1'b0;
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      beat_a("mrst_re", k);
    end
    @(negedge clk);
    idle_chk("mrst_end");

    // Level hold: done high for 10 cycles yields exactly one job.
    beats = 0;
    done = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (out_valid && out_ready) beats++;
      if (k == 9) done = 1'b0;
    end
    chk("lvl_beats", 64'(beats), 64'd4);
    idle_chk("lvl_end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
